// File: rtl/eq_band_gain_stage_pkg.sv
// Shared equalizer widths, sample limits and the round-and-saturate helper
// used by the gain stages and the band summer.
package eq_band_gain_stage_pkg;

    localparam int EQ_DATA_W = 16;
    localparam int EQ_GAIN_W = 16;
    localparam int EQ_FRAC_W = 8;
    localparam int EQ_PROD_W = EQ_DATA_W + EQ_GAIN_W + EQ_FRAC_W;
    localparam int EQ_RND_W  = EQ_PROD_W - EQ_FRAC_W + 1;

    localparam logic signed [EQ_DATA_W-1:0] SAMPLE_MAX = {1'b0, {(EQ_DATA_W-1){1'b1}}};
    localparam logic signed [EQ_DATA_W-1:0] SAMPLE_MIN = {1'b1, {(EQ_DATA_W-1){1'b0}}};

    localparam logic signed [EQ_PROD_W:0] ROUND_HALF = (EQ_PROD_W+1)'(2 ** (EQ_FRAC_W - 1));

    typedef struct packed {
        logic signed [EQ_DATA_W-1:0] sample;
        logic                        sat;
    } sat_res_t;

    // Round half toward +inf, drop the fraction, clip to the sample range.
    function automatic sat_res_t round_sat(input logic signed [EQ_PROD_W-1:0] acc);
        logic signed [EQ_PROD_W:0]  biased;
        logic signed [EQ_RND_W-1:0] r;
        sat_res_t                   res;
        biased = {acc[EQ_PROD_W-1], acc} + ROUND_HALF;
        r      = EQ_RND_W'(biased >>> EQ_FRAC_W);
        if (r > EQ_RND_W'(SAMPLE_MAX)) begin
            res.sample = SAMPLE_MAX;
            res.sat    = 1'b1;
        end else if (r < EQ_RND_W'(SAMPLE_MIN)) begin
            res.sample = SAMPLE_MIN;
            res.sat    = 1'b1;
        end else begin
            res.sample = EQ_DATA_W'(r);
            res.sat    = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/eq_band_gain_stage_gain_ramp.sv
// Current-gain register that walks toward the target gain by at most one
// step per accepted sample, never overshooting; frozen when no sample is taken.
module eq_band_gain_stage_gain_ramp
    import eq_band_gain_stage_pkg::*;
#(
    parameter int GAIN_W    = EQ_GAIN_W,
    parameter int FRAC_W    = EQ_FRAC_W,
    parameter int RAMP_STEP = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [GAIN_W-1:0]         gain_in,
    input  logic                             advance,
    output logic signed [GAIN_W+FRAC_W-1:0]  g_cur,
    output logic                             ramp_busy
);

    localparam int GW = GAIN_W + FRAC_W;
    localparam logic signed [GW:0]   STEP_W = (GW+1)'(RAMP_STEP);
    localparam logic signed [GW-1:0] STEP_G = GW'(RAMP_STEP);

    logic signed [GW-1:0] target;
    logic signed [GW-1:0] g_nxt;
    logic signed [GW:0]   diff;

    assign target    = {gain_in, {FRAC_W{1'b0}}};
    // One extra bit so target - g_cur cannot wrap at the extremes.
    assign diff      = {target[GW-1], target} - {g_cur[GW-1], g_cur};
    assign ramp_busy = (g_cur != target);

    always_comb begin
        g_nxt = target;
        if (diff > STEP_W) begin
            g_nxt = g_cur + STEP_G;
        end else if (diff < -STEP_W) begin
            g_nxt = g_cur - STEP_G;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cur <= '0;
        end else if (advance) begin
            g_cur <= g_nxt;
        end
    end

endmodule

// File: rtl/eq_band_gain_stage.sv
// Per-band ramped gain: product registered on accept, rounded/saturated next stage.
// 2-cycle latency, 1 sample/clk; a stalled output freezes both stages and the ramp.
module eq_band_gain_stage
    import eq_band_gain_stage_pkg::*;
#(
    parameter int DATA_W    = EQ_DATA_W,
    parameter int GAIN_W    = EQ_GAIN_W,
    parameter int FRAC_W    = EQ_FRAC_W,
    parameter int RAMP_STEP = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [GAIN_W-1:0] gain_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     sat_flag,
    output logic                     ramp_busy
);

    localparam int GW = GAIN_W + FRAC_W;
    localparam int PW = DATA_W + GW;

    logic                 en;
    logic                 accept;
    logic                 s1_valid;
    logic signed [PW-1:0] product;
    logic signed [GW-1:0] g_cur;
    sat_res_t             rs;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    eq_band_gain_stage_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .FRAC_W    (FRAC_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .gain_in   (gain_in),
        .advance   (accept),
        .g_cur     (g_cur),
        .ramp_busy (ramp_busy)
    );

    always_comb rs = round_sat(EQ_PROD_W'(product));

    // Product uses the gain in force before this accept's ramp update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            product  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (accept) begin
                product <= PW'(in_sample) * PW'(g_cur);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            sat_flag   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sample <= DATA_W'(rs.sample);
                sat_flag   <= rs.sat;
            end
        end
    end

endmodule

// File: tb/tb_eq_band_gain_stage.sv
// Self-checking bench: table vectors, directed ramp/stall/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_eq_band_gain_stage;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] gain_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_sample;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_sample;
    logic               sat_flag;
    logic               ramp_busy;

    always #5 clk = ~clk;

    eq_band_gain_stage dut (
        .clk        (clk),
        .rst        (rst),
        .gain_in    (gain_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .sat_flag   (sat_flag),
        .ramp_busy  (ramp_busy)
    );

    typedef struct {
        int val;
        int sat;
    } exp_t;

    typedef struct {
        int gain;
        int sample;
        int exp_out;
        int exp_sat;
    } vec_t;

    exp_t expq[$];
    int   log_out[$];
    vec_t vecs[7];
    int   mdl_g;
    int   checks;
    int   failures;
    int   n_acc;
    int   n_out;
    int   last_out;
    int   last_sat;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input int expv);
        if (idx < log_out.size()) begin
            chk(name, log_out[idx], expv);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: only %0d outputs seen, expected value %0d at index %0d",
                     name, log_out.size(), expv, idx);
        end
    endtask

    // Gain is in units of 1/256; output = round(x * g / 256), then clipped.
    task automatic model_accept(input int x);
        longint p;
        longint r;
        int     tgt;
        exp_t   e;
        p     = longint'(x) * longint'(mdl_g);
        r     = (p + 128) >>> 8;
        e.sat = 0;
        if (r > 32767) begin
            r = 32767;
            e.sat = 1;
        end else if (r < -32768) begin
            r = -32768;
            e.sat = 1;
        end
        e.val = int'(r);
        expq.push_back(e);
        tgt = int'(gain_in) * 256;
        if (mdl_g < tgt) mdl_g += ((tgt - mdl_g) < 16) ? (tgt - mdl_g) : 16;
        else if (mdl_g > tgt) mdl_g -= ((mdl_g - tgt) < 16) ? (mdl_g - tgt) : 16;
        n_acc++;
    endtask

    task automatic step(input bit v, input int s, input bit ordy);
        exp_t e;
        in_valid  = v;
        in_sample = 16'(s);
        out_ready = ordy;
        #1;
        chk("ramp_busy", ramp_busy, longint'(mdl_g != int'(gain_in) * 256));
        chk("g_cur", dut.u_ramp.g_cur, mdl_g);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: got %0d with no sample expected", out_sample);
            end else begin
                e = expq.pop_front();
                chk("out_sample", out_sample, e.val);
                chk("sat_flag", sat_flag, e.sat);
                last_out = int'(out_sample);
                last_sat = int'(sat_flag);
                log_out.push_back(int'(out_sample));
                n_out++;
            end
        end
        if (in_valid && in_ready) model_accept(s);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_g_cur", dut.u_ramp.g_cur, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        log_out.delete();
        mdl_g = 0;
        n_acc = 0;
        n_out = 0;
    endtask

    initial begin
        int held;
        int g0;
        int prev_g;
        int peak;

        checks   = 0;
        failures = 0;
        n_acc    = 0;
        n_out    = 0;
        mdl_g    = 0;
        last_out = 0;
        last_sat = 0;

        vecs[0] = '{gain: 3,  sample: 20000,  exp_out: 32767,  exp_sat: 1};
        vecs[1] = '{gain: 3,  sample: -20000, exp_out: -32768, exp_sat: 1};
        vecs[2] = '{gain: 3,  sample: 10000,  exp_out: 30000,  exp_sat: 0};
        vecs[3] = '{gain: -2, sample: 20000,  exp_out: -32768, exp_sat: 1};
        vecs[4] = '{gain: -2, sample: -16384, exp_out: 32767,  exp_sat: 1};
        vecs[5] = '{gain: 1,  sample: -1000,  exp_out: -1000,  exp_sat: 0};
        vecs[6] = '{gain: 0,  sample: 12345,  exp_out: 0,      exp_sat: 0};

        // Reset held with traffic offered.
        rst       = 1'b1;
        gain_in   = 16'sd1;
        in_valid  = 1'b1;
        in_sample = 16'sd1000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sample", out_sample, 0);
        chk("reset_sat_flag", sat_flag, 0);
        chk("reset_g_cur", dut.u_ramp.g_cur, 0);
        rst = 1'b0;

        // Ramp 0 -> 1 with constant input.
        repeat (20) step(1, 1000, 1);
        repeat (3) step(0, 0, 1);
        chk_log("ramp_out0", 0, 0);
        chk_log("ramp_out1", 1, 63);
        chk_log("ramp_out2", 2, 125);
        chk_log("ramp_out3", 3, 188);
        chk_log("ramp_out16", 16, 1000);
        chk("ramp_settled_busy", ramp_busy, 0);

        // Stall mid-ramp toward gain 2.
        gain_in = 16'sd2;
        for (int i = 0; i < 3; i++) step(1, 1000 + i, 1);
        held = int'(out_sample);
        g0   = int'(dut.u_ramp.g_cur);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'sd2000;
            out_ready = 1'b0;
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_sample", out_sample, held);
            chk("stall_g_cur", dut.u_ramp.g_cur, g0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) step(1, 1100 + i, 1);
        repeat (4) step(0, 0, 1);
        chk("stall_count", n_out, n_acc);
        chk("stall_queue_empty", expq.size(), 0);

        // Settled-gain vectors, including saturation and negative gains.
        foreach (vecs[k]) begin
            gain_in = 16'(vecs[k].gain);
            repeat (90) step(1, 0, 1);
            step(1, vecs[k].sample, 1);
            repeat (4) step(0, 0, 1);
            chk($sformatf("vec%0d_out", k), last_out, vecs[k].exp_out);
            chk($sformatf("vec%0d_sat", k), last_sat, vecs[k].exp_sat);
        end

        // Ramp up to 3, reverse to 0 after 10 accepts.
        pulse_reset();
        gain_in = 16'sd3;
        repeat (10) step(1, 100, 1);
        chk("rev_peak", dut.u_ramp.g_cur, 160);
        gain_in = 16'sd0;
        prev_g  = int'(dut.u_ramp.g_cur);
        peak    = prev_g;
        for (int i = 0; i < 12; i++) begin
            step(1, 100, 1);
            chk("rev_monotone", longint'(int'(dut.u_ramp.g_cur) <= prev_g), 1);
            chk("rev_no_undershoot", longint'(int'(dut.u_ramp.g_cur) >= 0), 1);
            prev_g = int'(dut.u_ramp.g_cur);
        end
        chk("rev_peak_held", peak, 160);
        chk("rev_final_g", dut.u_ramp.g_cur, 0);
        chk("rev_final_busy", ramp_busy, 0);

        // Reset mid-stream at gain 2.
        gain_in = 16'sd2;
        repeat (40) step(1, 1000, 1);
        pulse_reset();
        repeat (4) step(1, 1000, 1);
        chk_log("post_reset_first", 0, 0);

        // Random traffic, gains and backpressure.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) gain_in = 16'(int'($urandom_range(0, 8)) - 4);
            step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 9) < 7));
        end
        repeat (6) step(0, 0, 1);
        chk("final_queue_empty", expq.size(), 0);
        chk("final_count", n_out, n_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eq_band_gain_stage.md
Name: eq_band_gain_stage

Overview:
Applies the per-band gain code from the gain selector to one equalizer band's sample stream. Sits directly downstream of the gain selector and in line with the band filter output; its result feeds the band summer.
Gain changes are ramped linearly, one step per accepted sample, to avoid zipper noise. Output is rounded and saturated to the sample width.
Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 16, width of gain_in (signed integer gain code)
FRAC_W, 8, fractional bits of the internal ramped gain
RAMP_STEP, 16, ramp increment per accepted sample, in units of 2^-FRAC_W (16 = 1/16 gain unit)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
gain_in  in  GAIN_W  signed target gain (integer) from gain selector; may change any cycle
in_valid  in  1  in_sample valid
in_ready  out  1  stage accepts in_sample this cycle
in_sample  in  DATA_W  signed band sample
out_valid  out  1  out_sample valid
out_ready  in  1  downstream accepts out_sample
out_sample  out  DATA_W  signed gained sample
sat_flag  out  1  out_sample was clipped; qualified by out_valid
ramp_busy  out  1  current gain differs from target

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_sample=0, sat_flag=0, stage-1 valid=0. Current gain g_cur=0 (muted).
- target = gain_in sign-extended to GAIN_W+FRAC_W bits, shifted left FRAC_W. g_cur is a signed GAIN_W+FRAC_W register.
- ramp_busy = (g_cur != target), combinational from the register and the input.
- Pipeline enable en = !out_valid || out_ready. Also require: stage-1 advances only when en. Then in_ready = en, so there is no bubble when the output is free.
- Accept = in_valid && in_ready.
  - On accept, stage 1 registers product = in_sample * g_cur, using g_cur before its update. Product is full width, DATA_W+GAIN_W+FRAC_W signed.
  - On the same edge g_cur moves toward target:
    - g_cur < target: g_cur += min(RAMP_STEP, target-g_cur).
    - g_cur > target: g_cur -= min(RAMP_STEP, g_cur-target).
    - equal: hold.
  - No overshoot. g_cur never changes without an accepted sample.
- When en and stage-1 is valid, stage 2 computes:
  - r = (product + 2^(FRAC_W-1)) >>> FRAC_W (round half toward +inf).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register out_sample = saturated r, sat_flag = (clipped), out_valid = 1.
- When en and stage-1 is not valid: out_valid=0. out_sample and sat_flag hold their values (don't-care).
- Latency: 2 clk from accept to out_valid when unstalled. Throughput: 1 sample/clk.
- Backpressure: while out_valid && !out_ready, out_sample and sat_flag hold stable, stage-1 holds, in_ready=0, and g_cur frozen. No sample is dropped or duplicated.
- Target change mid-ramp: the new target applies from the next accept; the ramp reverses direction if needed.
- Negative gain_in is legal; the same arithmetic and saturation apply.
- Reset mid-operation: in-flight samples are discarded and g_cur returns to 0.

Decomposition:
- Shared eq package holds:
  - DATA_W, GAIN_W, FRAC_W defaults.
  - SAMPLE_MAX/SAMPLE_MIN constants.
  - A saturate-and-round function shared with the band summer.
- One natural sub-module: gain_ramp (g_cur register, step/clamp logic, ramp_busy).
- Multiply and saturation stay in the top module.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, out_sample=0, sat_flag=0 while rst high. First outputs after release use g_cur=0, so out_sample=0.
- gain_in=1, constant in_sample=1000, out_ready=1:
  - Outputs in order: 0, 63 (1000*16/256=62.5 rounds up), 125, 188, … then 1000 from the 17th sample on.
  - ramp_busy deasserts after the 16th accept.
- Gain settled at 3:
  - in_sample=20000 -> out_sample=32767, sat_flag=1.
  - in_sample=-20000 -> out_sample=-32768, sat_flag=1.
  - in_sample=10000 -> 30000, sat_flag=0.
- Backpressure: stream 1000s at gain 1 and drop out_ready for 5 clk.
  - out_sample stays stable and in_ready=0 during the stall.
  - g_cur is unchanged.
  - After release the output sequence continues with no loss or duplicate (scoreboard count equal).
- Ramp 0→3 and switch gain_in to 0 after 10 accepts:
  - g_cur peaks at 160/256 and then decreases by 16 per accept back to 0.
  - Never overshoots; ramp_busy=0 at the end.
- Assert rst for 1 clk mid-stream at gain 2 -> out_valid drops immediately (async), and g_cur=0. The first post-reset output is 0.
